// File: rtl/sync_mem_sdp.sv
// Simple-dual-port synchronous RAM with byte enables,
// selectable read latency, collision mode and clear sweep.
module sync_mem_sdp #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 init_busy
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if ((WIDTH % 8) != 0) begin : g_bad_width
    $error("sync_mem_sdp: WIDTH must be a multiple of 8");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("sync_mem_sdp: READ_LAT must be 1 or 2");
  end

  typedef enum logic { CLEAR, READY } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              ready;
  logic              rfire;
  logic              hit;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdat;
  logic [NB-1:0]     lane_we;
  logic [WIDTH-1:0]  rword;
  logic              pv;
  logic [WIDTH-1:0]  pd;

  assign ready     = (state == READY);
  assign init_busy = (state == CLEAR);
  assign rfire     = rd_en & ready;
  assign hit       = wr_en & ready & (wr_addr == rd_addr);

  // FSM and sweep counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Sweep one entry per clock, then settle in READY for good
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == DEPTH[ADDR_W-1:0] - 1'b1)
          state_nx = READY;
      end
      READY: state_nx = READY;
    endcase
  end

  // Write port is borrowed by the sweep while clearing
  always_comb begin
    waddr   = wr_addr;
    wdat    = wr_data;
    lane_we = '0;
    if (!ready) begin
      waddr   = cnt;
      wdat    = '0;
      lane_we = '1;
    end else if (wr_en) begin
      lane_we = wr_be;
    end
  end

  // Storage array, byte-lane writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (lane_we[i])
        mem[waddr][8*i +: 8] <= wdat[8*i +: 8];
  end

  // Read word, optionally forwarding same-edge write lanes
  always_comb begin
    rword = mem[rd_addr];
    if (RDW_MODE == 1 && hit)
      for (int i = 0; i < NB; i++)
        if (wr_be[i])
          rword[8*i +: 8] = wr_data[8*i +: 8];
  end

  if (READ_LAT == 2) begin : g_lat2
    logic             s_valid;
    logic [WIDTH-1:0] s_data;

    // Extra stage between array and output register
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s_valid <= 1'b0;
        s_data  <= '0;
      end else begin
        s_valid <= rfire;
        if (rfire)
          s_data <= rword;
      end
    end

    assign pv = s_valid;
    assign pd = s_data;
  end else begin : g_lat1
    assign pv = rfire;
    assign pd = rword;
  end

  // Output register; data holds between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pv;
      if (pv)
        rd_data <= pd;
    end
  end

endmodule

// File: tb/tb_sync_mem_sdp.sv
// Bench for sync_mem_sdp: three configurations on shared stimulus,
// table-driven vectors feeding a per-instance scoreboard.
module tb_sync_mem_sdp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [15:0] rdd [3];
  logic        rv  [3];
  logic        ib  [3];

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] eo;
    logic [15:0] en;
  } vec_t;

  exp_t sb [3][$];
  int   lat [3] = '{1, 1, 2};
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   ready = 1'b0;
  vec_t tbl [38];

  always #5 clk = ~clk;

  sync_mem_sdp #(.WIDTH(16), .ADDR_W(4), .READ_LAT(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rv[0]),
    .init_busy(ib[0]));

  sync_mem_sdp #(.WIDTH(16), .ADDR_W(4), .READ_LAT(1), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rv[1]),
    .init_busy(ib[1]));

  sync_mem_sdp #(.WIDTH(16), .ADDR_W(4), .READ_LAT(2), .RDW_MODE(0)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_valid(rv[2]),
    .init_busy(ib[2]));

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa,
                              input logic [1:0] be, input logic [15:0] wd,
                              input logic re, input logic [3:0] ra,
                              input logic [15:0] eo, input logic [15:0] en);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd;
    v.re = re; v.ra = ra; v.eo = eo; v.en = en;
    return v;
  endfunction

  // Scoreboard: compare each completed read, flag late or spurious ones
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int p = 0; p < 3; p++) begin
      if (rv[p] === 1'b1) begin
        total++;
        if (sb[p].size() == 0) begin
          bad++;
          $display("FAIL spurious_valid p%0d cyc=%0d data=%h", p, cyc, rdd[p]);
        end else begin
          exp_t e;
          e = sb[p].pop_front();
          if (rdd[p] !== e.data || e.due != cyc) begin
            bad++;
            $display("FAIL rd_p%0d got=%h@%0d want=%h@%0d",
                     p, rdd[p], cyc, e.data, e.due);
          end
        end
      end else if (sb[p].size() > 0 && sb[p][0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_valid p%0d got=none@%0d want=%h@%0d",
                 p, cyc, sb[p][0].data, sb[p][0].due);
        void'(sb[p].pop_front());
      end
    end
  end

  task automatic drive(input vec_t v);
    @(negedge clk);
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_be   = v.be;
    wr_data = v.wd;
    rd_en   = v.re;
    rd_addr = v.ra;
    if (v.re && ready)
      for (int p = 0; p < 3; p++)
        sb[p].push_back('{data: (p == 1) ? v.en : v.eo, due: cyc + lat[p]});
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #2;
      for (int p = 0; p < 3; p++)
        check($sformatf("busy_sweep_p%0d_c%0d", p, i), 16'(ib[p]),
              (i < 15) ? 16'h1 : 16'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++)
      tbl[i] = mk(0, 0, 0, 0, 1, 4'(i), 16'h0000, 16'h0000);
    tbl[16] = mk(1, 3, 2'b11, 16'hA5A5, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 1, 3, 16'hA5A5, 16'hA5A5);
    tbl[18] = mk(1, 3, 2'b01, 16'h1234, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 1, 3, 16'hA534, 16'hA534);
    tbl[20] = mk(1, 5, 2'b11, 16'h1111, 0, 0, 0, 0);
    tbl[21] = mk(1, 5, 2'b11, 16'h2222, 1, 5, 16'h1111, 16'h2222);
    tbl[22] = mk(0, 0, 0, 0, 1, 5, 16'h2222, 16'h2222);
    tbl[23] = mk(1, 5, 2'b11, 16'h1111, 0, 0, 0, 0);
    tbl[24] = mk(1, 5, 2'b10, 16'h2222, 1, 5, 16'h1111, 16'h2211);
    tbl[25] = mk(0, 0, 0, 0, 1, 5, 16'h2211, 16'h2211);
    tbl[26] = mk(1, 6, 2'b11, 16'hCAFE, 1, 3, 16'hA534, 16'hA534);
    tbl[27] = mk(0, 0, 0, 0, 1, 6, 16'hCAFE, 16'hCAFE);
    tbl[28] = mk(1, 7, 2'b00, 16'hF00D, 1, 7, 16'h0000, 16'h0000);
    tbl[29] = mk(0, 0, 0, 0, 1, 7, 16'h0000, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tbl[30+k] = mk(1, 4'(k), 2'b11, 16'h0100 + 16'(k), 0, 0, 0, 0);
      tbl[34+k] = mk(0, 0, 0, 0, 1, 4'(k),
                     16'h0100 + 16'(k), 16'h0100 + 16'(k));
    end

    // Requests held active through reset and the whole sweep
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_be   = 2'b11;
    wr_data = 16'hFFFF;
    rd_en   = 1'b1;
    rd_addr = 4'd2;
    #3 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("rst_valid_p%0d", p), 16'(rv[p]), 16'h0);
      check($sformatf("rst_data_p%0d", p), rdd[p], 16'h0000);
      check($sformatf("rst_busy_p%0d", p), 16'(ib[p]), 16'h1);
    end
    rst = 1'b1;
    wait_sweep();
    ready = 1'b1;

    for (int i = 0; i < 38; i++)
      drive(tbl[i]);
    for (int i = 0; i < 3; i++)
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int p = 0; p < 3; p++) begin
      check($sformatf("hold_data_p%0d", p), rdd[p], 16'h0103);
      check($sformatf("hold_valid_p%0d", p), 16'(rv[p]), 16'h0);
    end

    // Reset pulse with reads still in the pipeline
    drive(mk(1, 7, 2'b11, 16'hBEEF, 0, 0, 0, 0));
    drive(mk(0, 0, 0, 0, 1, 7, 16'hBEEF, 16'hBEEF));
    drive(mk(0, 0, 0, 0, 1, 7, 16'hBEEF, 16'hBEEF));
    @(posedge clk);
    #3;
    rst = 1'b0;
    ready = 1'b0;
    for (int p = 0; p < 3; p++)
      sb[p].delete();
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("midrst_valid_p%0d", p), 16'(rv[p]), 16'h0);
      check($sformatf("midrst_busy_p%0d", p), 16'(ib[p]), 16'h1);
      check($sformatf("midrst_data_p%0d", p), rdd[p], 16'h0000);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_sweep();
    ready = 1'b1;
    drive(mk(0, 0, 0, 0, 1, 7, 16'h0000, 16'h0000));
    for (int i = 0; i < 4; i++)
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int p = 0; p < 3; p++)
      check($sformatf("drain_p%0d", p), 16'(sb[p].size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
